// File: rtl/sync_1001_tx_if.sv
// rtl/sync_1001_tx_if.sv - request/serial-output bundle for the 1001-preamble serial transmitter
interface sync_1001_tx_if #(
    parameter int DW = 8
);
    logic          start;
    logic [DW-1:0] data;
    logic          ready;
    logic          ser_out;
    logic          ser_valid;
    logic          done;
    logic [7:0]    frame_cnt;

    // Requester side: issues frames and observes the serial stream
    modport master (
        output start,
        output data,
        input  ready,
        input  ser_out,
        input  ser_valid,
        input  done,
        input  frame_cnt
    );

    // Transmitter side
    modport slave (
        input  start,
        input  data,
        output ready,
        output ser_out,
        output ser_valid,
        output done,
        output frame_cnt
    );
endinterface

// File: rtl/sync_1001_tx.sv
// rtl/sync_1001_tx.sv - Moore FSM framing a payload as preamble 1001, LSB-first data, forced-0 gap
module sync_1001_tx #(
    parameter int DW      = 8,
    parameter int GAP_LEN = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    sync_1001_tx_if.slave      bus
);

    // A single-bit payload still needs a one-bit counter register.
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    // Preamble bit k is PRE_PAT[k]; the pattern reads the same in both directions.
    localparam logic [3:0] PRE_PAT = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t          state_q,     state_d;
    logic [1:0]      pre_idx_q,   pre_idx_d;
    logic [CW-1:0]   bit_cnt_q,   bit_cnt_d;
    logic [3:0]      gap_cnt_q,   gap_cnt_d;
    logic [DW-1:0]   shreg_q,     shreg_d;
    logic            ser_out_q,   ser_out_d;
    logic            ser_valid_q, ser_valid_d;
    logic            done_q,      done_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;

    // State register and registered outputs; reset aborts any frame in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pre_idx_q   <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            shreg_q     <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pre_idx_q   <= pre_idx_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            shreg_q     <= shreg_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Next state plus the output values for the cycle after the edge, so the
    // serial bit lines up with the state it belongs to without extra latency
    always_comb begin
        state_d     = state_q;
        pre_idx_d   = pre_idx_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        shreg_d     = shreg_q;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = PRE;
                    pre_idx_d   = 2'd0;
                    shreg_d     = bus.data;
                    ser_out_d   = PRE_PAT[0];
                    ser_valid_d = 1'b1;
                end
            end

            PRE: begin
                ser_valid_d = 1'b1;
                if (pre_idx_q == 2'd3) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    ser_out_d = shreg_q[0];
                end else begin
                    pre_idx_d = pre_idx_q + 2'd1;
                    ser_out_d = PRE_PAT[pre_idx_d];
                end
            end

            DATA: begin
                if (bit_cnt_q == CW'(DW - 1)) begin
                    state_d   = GAP;
                    gap_cnt_d = '0;
                end else begin
                    // Current bit sits in shreg_q[0]; shift to expose the next one
                    bit_cnt_d   = bit_cnt_q + CW'(1);
                    shreg_d     = shreg_q >> 1;
                    ser_out_d   = shreg_d[0];
                    ser_valid_d = 1'b1;
                end
            end

            GAP: begin
                if (gap_cnt_q == 4'(GAP_LEN - 1)) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ready is a pure state decode, so it is high during the done cycle too,
    // which is what lets a held start chain frames with one idle cycle between
    assign bus.ready     = (state_q == IDLE);
    assign bus.ser_out   = ser_out_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.done      = done_q;
    assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sync_1001_tx.sv
// tb/tb_sync_1001_tx.sv - randomized and directed self-checking bench for sync_1001_tx
module tb_sync_1001_tx;

    localparam int DW      = 8;
    localparam int GAP_LEN = 2;

    typedef struct packed {
        logic so;
        logic sv;
        logic dn;
        logic rdy;
    } rec_t;

    localparam rec_t IDLE_REC = 4'b0001;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sync_1001_tx_if #(.DW(DW)) bus ();

    sync_1001_tx #(.DW(DW), .GAP_LEN(GAP_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_done   = 0;
    int         det_cnt  = 0;
    bit         det_en   = 1'b0;
    logic [3:0] hist     = 4'b0;

    rec_t       cur      = IDLE_REC;
    rec_t       pending[$];
    logic [7:0] m_cnt    = 8'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a list of per-cycle output records queued on acceptance
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                pending.delete();
                cur   = IDLE_REC;
                m_cnt = 8'd0;
            end else begin
                if (bus.start === 1'b1 && cur.rdy) begin
                    logic [3:0]    pre;
                    logic [DW-1:0] d;
                    rec_t          r;
                    pre = 4'b1001;
                    d   = bus.data;
                    for (int k = 0; k < 4; k++) begin
                        r = '{so: pre[3-k], sv: 1'b1, dn: 1'b0, rdy: 1'b0};
                        pending.push_back(r);
                    end
                    for (int k = 0; k < DW; k++) begin
                        r = '{so: d[k], sv: 1'b1, dn: 1'b0, rdy: 1'b0};
                        pending.push_back(r);
                    end
                    for (int k = 0; k < GAP_LEN; k++) begin
                        r = '{so: 1'b0, sv: 1'b0, dn: 1'b0, rdy: 1'b0};
                        pending.push_back(r);
                    end
                    r = '{so: 1'b0, sv: 1'b0, dn: 1'b1, rdy: 1'b1};
                    pending.push_back(r);
                end
                if (pending.size() > 0) cur = pending.pop_front();
                else                    cur = IDLE_REC;
                if (cur.dn) m_cnt = m_cnt + 8'd1;
            end
        end
    end

    // Per-cycle comparison against the model, plus a loopback 1001 detector
    initial begin
        forever begin
            @(negedge clk);
            chk("ser_out",   64'(bus.ser_out),   64'(cur.so));
            chk("ser_valid", 64'(bus.ser_valid), 64'(cur.sv));
            chk("done",      64'(bus.done),      64'(cur.dn));
            chk("ready",     64'(bus.ready),     64'(cur.rdy));
            chk("frame_cnt", 64'(bus.frame_cnt), 64'(m_cnt));
            if (bus.done === 1'b1) n_done++;
            if (det_en) begin
                hist = {hist[2:0], bus.ser_out};
                if (hist == 4'b1001) det_cnt++;
            end else begin
                hist = 4'b0;
            end
        end
    end

    task automatic collect(input int n, output logic [63:0] got);
        got = '0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            got = {got[62:0], bus.ser_out};
        end
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic [63:0] g1, g2;
        bit          ok;
        int          done0;

        bus.start = 1'b0;
        bus.data  = '0;

        // Reset values, held with no activity
        #2;
        chk("rst_ready",     64'(bus.ready),     64'd1);
        chk("rst_ser_out",   64'(bus.ser_out),   64'd0);
        chk("rst_ser_valid", 64'(bus.ser_valid), 64'd0);
        chk("rst_done",      64'(bus.done),      64'd0);
        chk("rst_frame_cnt", 64'(bus.frame_cnt), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Basic A5 frame
        @(negedge clk);
        bus.start = 1'b1;
        bus.data  = 8'hA5;
        @(negedge clk);
        bus.start = 1'b0;
        bus.data  = 8'($urandom);
        collect(14, g1);
        chk("a5_stream", g1, 64'(14'b10011010010100));
        @(negedge clk);
        chk("a5_done", 64'(bus.done), 64'd1);
        chk("a5_cnt",  64'(bus.frame_cnt), 64'd1);

        // Back-to-back with start held: 01 then 80
        @(negedge clk);
        bus.start = 1'b1;
        bus.data  = 8'h01;
        @(negedge clk);
        bus.data  = 8'h80;
        collect(29, g1);
        chk("b2b_stream", g1, 64'(29'b1001_10000000_00_0_1001_00000001_00));
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_done", 64'(bus.done), 64'd1);
        chk("b2b_cnt",  64'(bus.frame_cnt), 64'd3);

        // Start while busy is ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.data  = 8'h00;
        @(negedge clk);
        bus.start = 1'b0;
        collect(6, g1);
        bus.start = 1'b1;
        bus.data  = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        collect(8, g2);
        chk("busy_stream", {50'd0, g1[5:0], g2[7:0]}, 64'(14'b10010000000000));
        @(negedge clk);
        chk("busy_done", 64'(bus.done), 64'd1);
        repeat (3) @(negedge clk);
        chk("busy_cnt", 64'(bus.frame_cnt), 64'd4);

        // Loopback detector over three zero-payload frames
        det_en = 1'b1;
        det_cnt = 0;
        bus.start = 1'b1;
        bus.data  = 8'h00;
        for (int k = 0; k < 3; k++) begin
            wait_done(40, ok);
            chk("loop_timeout", 64'(ok), 64'd1);
        end
        bus.start = 1'b0;
        @(negedge clk);
        det_en = 1'b0;
        chk("loop_detect", 64'(det_cnt), 64'd3);

        // Reset during DATA bit 3, checked before any clock edge
        @(negedge clk);
        bus.start = 1'b1;
        bus.data  = 8'($urandom);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        done0 = n_done;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_ser_out",   64'(bus.ser_out),   64'd0);
        chk("mid_ser_valid", 64'(bus.ser_valid), 64'd0);
        chk("mid_ready",     64'(bus.ready),     64'd1);
        chk("mid_frame_cnt", 64'(bus.frame_cnt), 64'd0);
        chk("mid_done",      64'(bus.done),      64'd0);
        bus.start = 1'b1;
        bus.data  = 8'h3C;
        repeat (2) @(negedge clk);
        chk("mid_no_done", 64'(n_done - done0), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("post_rst_busy", 64'(bus.ready),   64'd0);
        chk("post_rst_pre",  64'(bus.ser_out), 64'd1);
        wait_done(40, ok);
        chk("post_rst_timeout", 64'(ok), 64'd1);

        // Randomized traffic checked against the model every cycle
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.data  = 8'($urandom);
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);

        // Counter wrap over 256 frames
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        done0 = n_done;
        bus.start = 1'b1;
        for (int k = 0; k < 256; k++) begin
            bus.data = 8'($urandom);
            wait_done(40, ok);
            if (!ok) begin
                chk("wrap_timeout", 64'(ok), 64'd1);
                break;
            end
            if (k == 254) chk("wrap_255", 64'(bus.frame_cnt), 64'd255);
            if (k == 255) chk("wrap_0",   64'(bus.frame_cnt), 64'd0);
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk("wrap_dones", 64'(n_done - done0), 64'd256);
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_1001_tx.md
SYNC_1001_TX -- requirements
Module: sync_1001_tx

Interface
REQ-001 Parameter DW, default 8: payload width in bits; legal range 1..32.
REQ-002 Parameter GAP_LEN, default 2: number of forced-0 inter-frame gap cycles after the payload; legal range 1..15.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1: asynchronous, active-low reset; one clock, no other clock domains.
REQ-005 Port start  input  1: frame request; qualified by ready.
REQ-006 Port data  input  DW: payload; sampled only on an accepted start.
REQ-007 Port ready  output  1: high only in IDLE; the block can accept start.
REQ-008 Port ser_out  output  1: registered serial bit stream.
REQ-009 Port ser_valid  output  1: high while ser_out carries preamble or payload bits.
REQ-010 Port done  output  1: one-cycle pulse marking frame completion.
REQ-011 Port frame_cnt  output  8: count of completed frames.

Function
REQ-012 The block SHALL be a Moore FSM with states IDLE, PRE, DATA and GAP; all outputs are registered or decoded from state only.
REQ-013 Handshake: start SHALL be accepted on a rising edge where start=1 and ready=1; data is captured into a DW-bit shift register on that edge.
REQ-014 start while ready=0 SHALL be ignored; data changes after acceptance SHALL NOT affect the frame in flight.
REQ-015 On acceptance: IDLE->PRE; the first preamble bit SHALL appear on ser_out in the cycle right after the accepting edge (latency 1 cycle).
REQ-016 PRE: 4 cycles emitting 1,0,0,1 in that order; ser_valid=1; a 2-bit index counts 0..3, then PRE->DATA.
REQ-017 DATA: DW cycles emitting the captured payload LSB first; ser_valid=1; a bit counter counts 0..DW-1, then DATA->GAP.
REQ-018 GAP: GAP_LEN cycles with ser_out=0 and ser_valid=0, then GAP->IDLE.
REQ-019 IDLE: ser_out=0, ser_valid=0, ready=1.
REQ-020 done SHALL be 1 for exactly the first IDLE cycle after GAP, and 0 otherwise.
REQ-021 frame_cnt SHALL increment by 1 on the edge entering that done cycle, wrapping 255->0 with no saturation or flag.
REQ-022 Back-to-back: start=1 during the done cycle SHALL be accepted, giving exactly one IDLE cycle between frames.
REQ-023 Frame length SHALL be 4+DW+GAP_LEN cycles from the first preamble bit to the done cycle, independent of the payload value.

Reset
REQ-024 While rst_n=0, the block SHALL force state=IDLE, ser_out=0, ser_valid=0, done=0, ready=1, frame_cnt=0, shift register=0 and all counters=0, asynchronously and without a clock.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately: no done pulse and no frame_cnt increment.
REQ-026 After rst_n deasserts, the first start SHALL be accepted no earlier than the first rising edge with rst_n=1.

Verification
REQ-027 Basic frame, DW=8, GAP_LEN=2: start with data=8'hA5 -> ser_out=1,0,0,1,1,0,1,0,0,1,0,1,0,0; ser_valid high for the first 12 bits; done in cycle 15; frame_cnt=1.
REQ-028 Back-to-back: start held high, data 8'h01 then 8'h80 -> second preamble begins the cycle after done; payloads 1,0,0,0,0,0,0,0 then 0,0,0,0,0,0,0,1; frame_cnt=2.
REQ-029 Busy ignore: pulse start with data=8'hFF during DATA of an 8'h00 frame -> payload stays all zeros; only one done; frame_cnt=1.
REQ-030 Reset mid-frame: rst_n low during DATA bit 3 -> ser_out=0, ready=1 and frame_cnt=0 without a clock edge; no done pulse.
REQ-031 Wrap: 256 frames -> frame_cnt reads 255 after frame 255 and 0 after frame 256; done count equals 256.
REQ-032 Loopback: ser_out drives a 1001 detector -> detector output fires exactly once per frame, at the end of the preamble, when payload 8'h00 is used.
